pack_frame_ctrl: RTL and testbench

- Frame-level controller placed directly upstream of the 12-to-16 packer in the imager stream.
- On host command, opens a capture window of N frames (or continuous) and decimates frames 1-of-(decim+1).
- Gates the stream so only whole frames and their trailing headers pass.
- Drives the packer's enable so it changes only between frames; exports capture status and counters.

---
 rtl/pack_frame_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pack_frame_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_frame_ctrl.sv
// Frame-level capture controller ahead of the 12-to-16 packer: windows and decimates
// whole frames (plus their trailing headers) and only retimes the packer enable between frames.
module pack_frame_ctrl #(
  parameter int COUNT_W     = 16,
  parameter int DECIM_W     = 8,
  parameter int DTYPE_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [COUNT_W-1:0]     num_frames,
  input  logic [DECIM_W-1:0]     decim,
  input  logic                   pack_en_req,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [15:0]            datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]            datao,
  output logic                   pack_enable,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_W-1:0]     frames_passed,
  output logic [COUNT_W-1:0]     frames_dropped
);

  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START  = DTYPE_WIDTH'(1);
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END    = DTYPE_WIDTH'(2);
  localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_START = DTYPE_WIDTH'(3);
  localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_END   = DTYPE_WIDTH'(5);

  typedef enum logic [2:0] {
    IDLE, ARMED, FRAME_PASS, FRAME_SKIP, HDR_PASS, TAIL
  } state_t;

  state_t               state, state_nxt;
  logic [DECIM_W-1:0]   skip_cnt, skip_nxt;
  logic [DECIM_W-1:0]   decim_q, decim_nxt;
  logic [COUNT_W-1:0]   remaining, remaining_nxt;
  logic [COUNT_W-1:0]   passed_nxt, dropped_nxt;
  logic                 cont_q, cont_nxt;
  logic                 stop_pending, stop_pend_nxt;
  logic                 last_pass, last_pass_nxt;
  logic                 hdr_due, hdr_due_nxt;
  logic                 done_nxt;
  logic                 pass;
  logic                 pen_load;

  logic                 is_fs, is_fe, is_hs, is_he;
  logic [COUNT_W-1:0]   passed_inc, dropped_inc;

  assign is_fs = dvi && (dtypei == DT_FRAME_START);
  assign is_fe = dvi && (dtypei == DT_FRAME_END);
  assign is_hs = dvi && (dtypei == DT_HEADER_START);
  assign is_he = dvi && (dtypei == DT_HEADER_END);

  assign passed_inc  = (frames_passed  == '1) ? frames_passed  : frames_passed  + 1'b1;
  assign dropped_inc = (frames_dropped == '1) ? frames_dropped : frames_dropped + 1'b1;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    skip_nxt      = skip_cnt;
    decim_nxt     = decim_q;
    remaining_nxt = remaining;
    cont_nxt      = cont_q;
    stop_pend_nxt = stop_pending;
    last_pass_nxt = last_pass;
    hdr_due_nxt   = hdr_due;
    passed_nxt    = frames_passed;
    dropped_nxt   = frames_dropped;
    done_nxt      = 1'b0;
    pass          = 1'b0;
    pen_load      = 1'b0;

    case (state)
      IDLE: begin
        pen_load = 1'b1;
        if (start && !stop) begin
          remaining_nxt = num_frames;
          decim_nxt     = decim;
          cont_nxt      = continuous;
          skip_nxt      = '0;
          passed_nxt    = '0;
          dropped_nxt   = '0;
          stop_pend_nxt = 1'b0;
          last_pass_nxt = 1'b0;
          hdr_due_nxt   = 1'b0;
          if (!continuous && (num_frames == '0)) done_nxt = 1'b1;
          else                                   state_nxt = ARMED;
        end
      end

      ARMED: begin
        // hdr_due keeps the enable frozen in the gap between a passed frame and its header
        pen_load = !is_fs && !is_hs && !hdr_due;
        if (stop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (is_fs) begin
          hdr_due_nxt = 1'b0;
          if (skip_cnt == '0) begin
            pass      = 1'b1;
            skip_nxt  = decim_q;
            state_nxt = FRAME_PASS;
          end else begin
            skip_nxt    = skip_cnt - 1'b1;
            dropped_nxt = dropped_inc;
            state_nxt   = FRAME_SKIP;
          end
        end else if (is_hs && last_pass) begin
          pass      = 1'b1;
          state_nxt = HDR_PASS;
        end
      end

      FRAME_PASS: begin
        pass = 1'b1;
        if (stop) stop_pend_nxt = 1'b1;
        if (is_fe) begin
          passed_nxt    = passed_inc;
          last_pass_nxt = 1'b1;
          hdr_due_nxt   = 1'b1;
          if (!cont_q && (remaining != '0)) remaining_nxt = remaining - 1'b1;
          if ((!cont_q && (remaining == COUNT_W'(1))) || stop_pend_nxt) state_nxt = TAIL;
          else                                                          state_nxt = ARMED;
        end
      end

      FRAME_SKIP: begin
        if (stop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (is_fe) begin
          last_pass_nxt = 1'b0;
          state_nxt     = ARMED;
        end
      end

      HDR_PASS: begin
        pass = 1'b1;
        if (stop) stop_pend_nxt = 1'b1;
        if (is_he) begin
          hdr_due_nxt = 1'b0;
          if (stop_pend_nxt) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ARMED;
          end
        end
      end

      TAIL: begin
        if (stop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (is_hs) begin
          pass          = 1'b1;
          stop_pend_nxt = 1'b1;
          state_nxt     = HDR_PASS;
        end else if (is_fs) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state          <= IDLE;
      skip_cnt       <= '0;
      decim_q        <= '0;
      remaining      <= '0;
      cont_q         <= 1'b0;
      stop_pending   <= 1'b0;
      last_pass      <= 1'b0;
      hdr_due        <= 1'b0;
      frames_passed  <= '0;
      frames_dropped <= '0;
      done           <= 1'b0;
      dvo            <= 1'b0;
      dtypeo         <= '0;
      datao          <= '0;
      pack_enable    <= 1'b0;
    end else begin
      state          <= state_nxt;
      skip_cnt       <= skip_nxt;
      decim_q        <= decim_nxt;
      remaining      <= remaining_nxt;
      cont_q         <= cont_nxt;
      stop_pending   <= stop_pend_nxt;
      last_pass      <= last_pass_nxt;
      hdr_due        <= hdr_due_nxt;
      frames_passed  <= passed_nxt;
      frames_dropped <= dropped_nxt;
      done           <= done_nxt;
      dvo            <= dvi && pass;
      dtypeo         <= dtypei;
      datao          <= datai;
      if (pen_load) pack_enable <= pack_en_req;
    end
  end

endmodule

// File: tb/tb_pack_frame_ctrl.sv
// Self-checking bench for pack_frame_ctrl: a frame-level model builds the per-cycle
// expected outputs while the stimulus is queued, and one compare process checks every cycle.
module tb_pack_frame_ctrl;

  localparam int CW = 16;
  localparam int DW = 8;
  localparam int TW = 3;

  localparam logic [2:0] PIX = 3'd0, FS = 3'd1, FE = 3'd2, HS = 3'd3, HDR = 3'd4, HE = 3'd5;

  logic          clk = 1'b0;
  logic          resetb;
  logic          start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [CW-1:0] num_frames = '0;
  logic [DW-1:0] decim = '0;
  logic          pack_en_req = 1'b0;
  logic          dvi = 1'b0;
  logic [TW-1:0] dtypei = '0;
  logic [15:0]   datai = '0;
  logic          dvo;
  logic [TW-1:0] dtypeo;
  logic [15:0]   datao;
  logic          pack_enable, busy, done;
  logic [CW-1:0] frames_passed, frames_dropped;

  pack_frame_ctrl #(.COUNT_W(CW), .DECIM_W(DW), .DTYPE_WIDTH(TW)) dut (
    .clk(clk), .resetb(resetb), .start(start), .stop(stop), .continuous(continuous),
    .num_frames(num_frames), .decim(decim), .pack_en_req(pack_en_req), .dvi(dvi),
    .dtypei(dtypei), .datai(datai), .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
    .pack_enable(pack_enable), .busy(busy), .done(done),
    .frames_passed(frames_passed), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         dv;
    logic [2:0] dt;
    logic [15:0] data;
    bit         st, sp, ps, dn, bz, pen, pen_chk, pen_exp;
  } vec_t;

  vec_t q[$];
  vec_t pend;
  bit   chk_en = 1'b0;
  bit   bld_busy = 1'b0;
  bit   g_pen = 1'b0;
  int   tests = 0, fails = 0, dvo_cnt = 0, done_cnt = 0;
  int   exp_p, exp_d;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit dv, input logic [2:0] dt, input bit st, input bit sp,
                      input bit ps, input bit dn, input bit pc, input bit pe);
    vec_t v;
    v.dv = dv; v.dt = dt; v.data = 16'($urandom);
    v.st = st; v.sp = sp; v.ps = ps && dv; v.dn = dn;
    if (dn) bld_busy = 1'b0;
    v.bz = bld_busy; v.pen = g_pen; v.pen_chk = pc; v.pen_exp = pe;
    q.push_back(v);
  endtask

  // One frame: FS, 6 pixels, FE, 2 idle, HS, 2 header words, HE, 2 idle
  task automatic frame(input bit pf, input bit last, input int stop_idx,
                       input int toggle_idx, input bit chk_pen);
    bit held;
    held = g_pen;
    for (int i = 0; i < 16; i++) begin
      logic [2:0] dt;
      bit dv;
      dv = 1'b1;
      case (i)
        0:             dt = FS;
        7:             dt = FE;
        8, 9, 14, 15:  begin dt = PIX; dv = 1'b0; end
        10:            dt = HS;
        11, 12:        dt = HDR;
        13:            dt = HE;
        default:       dt = PIX;
      endcase
      if (i == toggle_idx) g_pen = ~g_pen;
      push(dv, dt, 1'b0, i == stop_idx, pf, last && (i == 13), chk_pen && (i <= 13), held);
    end
  endtask

  // Frame k of the window passes when k is a multiple of decim+1 and the quota is not yet met
  task automatic capture(input int num, input int dec, input bit cont, input int nfr,
                         output int passed, output int dropped);
    int taken;
    bit active, pf, last;
    num_frames = CW'(num);
    decim      = DW'(dec);
    continuous = cont;
    taken = 0;
    dropped = 0;
    if (!cont && num == 0) begin
      push(1'b0, PIX, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      active = 1'b0;
    end else begin
      bld_busy = 1'b1;
      push(1'b0, PIX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      active = 1'b1;
    end
    for (int k = 0; k < nfr; k++) begin
      pf = active && (k % (dec + 1) == 0);
      if (active && !pf) dropped++;
      last = pf && !cont && (taken + 1 == num);
      frame(pf, last, -1, -1, 1'b0);
      if (pf) taken++;
      if (last) active = 1'b0;
    end
    passed = taken;
  endtask

  task automatic apply_stimulus();
    foreach (q[i]) begin
      @(negedge clk);
      dvi = q[i].dv; dtypei = q[i].dt; datai = q[i].data;
      start = q[i].st; stop = q[i].sp; pack_en_req = q[i].pen;
      pend = q[i];
      chk_en = 1'b1;
    end
    @(negedge clk);
    dvi = 1'b0; start = 1'b0; stop = 1'b0;
    chk_en = 1'b0;
    q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_dvo"}, dvo, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_pack_enable"}, pack_enable, 0);
    check_output({tag, "_frames_passed"}, frames_passed, 0);
    check_output({tag, "_frames_dropped"}, frames_dropped, 0);
    check_output({tag, "_datao"}, datao, 0);
    check_output({tag, "_dtypeo"}, dtypeo, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check_output("dvo", dvo, pend.ps);
      check_output("datao", datao, pend.data);
      check_output("dtypeo", dtypeo, pend.dt);
      check_output("done", done, pend.dn);
      check_output("busy", busy, pend.bz);
      if (pend.pen_chk) check_output("pack_enable", pack_enable, pend.pen_exp);
      if (dvo)  dvo_cnt++;
      if (done) done_cnt++;
    end
  end

  initial begin
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    resetb = 1'b1;

    // two-frame window, third frame falls outside it
    dvo_cnt = 0; done_cnt = 0;
    capture(2, 0, 1'b0, 3, exp_p, exp_d);
    apply_stimulus();
    check_output("s1_passed_model", frames_passed, exp_p);
    check_output("s1_passed_lit", frames_passed, 2);
    check_output("s1_dropped", frames_dropped, exp_d);
    check_output("s1_dvo_words", dvo_cnt, 24);
    check_output("s1_done_pulses", done_cnt, 1);

    // continuous with decim=2, closed by a stop while armed
    capture(0, 2, 1'b1, 7, exp_p, exp_d);
    push(1'b0, PIX, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus();
    check_output("s2_passed_model", frames_passed, exp_p);
    check_output("s2_passed_lit", frames_passed, 3);
    check_output("s2_dropped_model", frames_dropped, exp_d);
    check_output("s2_dropped_lit", frames_dropped, 4);

    // stop on pixel 3 of the second passed frame
    num_frames = 5; decim = 0; continuous = 1'b0;
    bld_busy = 1'b1;
    push(1'b0, PIX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, -1, -1, 1'b0);
    frame(1'b1, 1'b1, 3, -1, 1'b0);
    frame(1'b0, 1'b0, -1, -1, 1'b0);
    apply_stimulus();
    check_output("s3_passed", frames_passed, 2);

    // packer enable request toggled mid-frame
    g_pen = 1'b1;
    push(1'b0, PIX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, PIX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    num_frames = 2; decim = 0; continuous = 1'b0;
    bld_busy = 1'b1;
    push(1'b0, PIX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, -1, 4, 1'b1);
    frame(1'b1, 1'b1, -1, -1, 1'b1);
    apply_stimulus();
    check_output("s4_pen_final", pack_enable, 0);

    // start+stop together, then start with an empty window
    done_cnt = 0;
    num_frames = 3;
    push(1'b0, PIX, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, -1, -1, 1'b0);
    capture(0, 0, 1'b0, 1, exp_p, exp_d);
    apply_stimulus();
    check_output("s5_done_pulses", done_cnt, 1);
    check_output("s5_passed", frames_passed, 0);

    // asynchronous reset in the middle of a passed frame
    num_frames = 4; decim = 0; continuous = 1'b0;
    bld_busy = 1'b1;
    push(1'b0, PIX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, FS, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b1, PIX, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus();
    check_output("s6_busy_before", busy, 1);
    @(negedge clk);
    dvi = 1'b1; dtypei = PIX; datai = 16'h1234;
    #2 resetb = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    resetb = 1'b1;
    bld_busy = 1'b0;
    @(posedge clk);
    #1 check_output("s6_dvo_after_release", dvo, 0);
    push(1'b1, PIX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, FE,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, HS,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, HDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, HE,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, -1, -1, 1'b0);
    capture(1, 0, 1'b0, 1, exp_p, exp_d);
    apply_stimulus();
    check_output("s6_passed", frames_passed, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
